// File: rtl/data_sram_responder.sv
// Responder side of the core data SRAM interface: word RAM behind the low address space plus
// a small MMIO window (LED, NUM, SWITCH, TIMER). Read data is returned one cycle after the request.
module data_sram_responder #(
    parameter int unsigned RAM_AW     = 12,
    parameter logic [15:0] MMIO_HI    = 16'hBFAF,
    parameter logic [31:0] TIMER_STEP = 32'd1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led_out,
    output logic [31:0] num_out
);

    localparam int unsigned DEPTH      = 1 << RAM_AW;
    localparam int unsigned LANES      = 4;
    localparam logic [15:0] OFF_LED    = 16'hF000;
    localparam logic [15:0] OFF_NUM    = 16'hF010;
    localparam logic [15:0] OFF_SWITCH = 16'hF020;
    localparam logic [15:0] OFF_TIMER  = 16'hE000;

    logic [31:0]       mem [DEPTH];
    logic [15:0]       led_q;
    logic [31:0]       num_q;
    logic [31:0]       timer_q;
    logic [7:0]        switch_q;
    logic [31:0]       rdata_q;

    logic [RAM_AW-1:0] ram_idx_c;
    logic [15:0]       offset_c;
    logic              is_mmio_c;
    logic              wr_c;
    logic [31:0]       read_c;
    logic [15:0]       led_nxt_c;
    logic [31:0]       num_nxt_c;
    logic [31:0]       timer_nxt_c;

    assign ram_idx_c = data_sram_addr[RAM_AW+1:2];
    assign offset_c  = data_sram_addr[15:0];
    assign is_mmio_c = (data_sram_addr[31:16] == MMIO_HI);
    assign wr_c      = data_sram_en && (data_sram_wen != 4'b0000);

    // Read mux sees pre-edge contents, which gives read-first behaviour everywhere.
    always_comb begin
        read_c = 32'h0;
        if (is_mmio_c) begin
            case (offset_c)
                OFF_LED:    read_c = {16'h0, led_q};
                OFF_NUM:    read_c = num_q;
                OFF_SWITCH: read_c = {24'h0, switch_q};
                OFF_TIMER:  read_c = timer_q;
                default:    read_c = 32'h0;
            endcase
        end else begin
            read_c = mem[ram_idx_c];
        end
    end

    // Next values of the RW registers; written lanes override, TIMER lanes not written keep counting.
    always_comb begin
        led_nxt_c   = led_q;
        num_nxt_c   = num_q;
        timer_nxt_c = timer_q + TIMER_STEP;
        if (wr_c && is_mmio_c) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (data_sram_wen[i]) begin
                    if (offset_c == OFF_NUM)   num_nxt_c[8*i +: 8]   = data_sram_wdata[8*i +: 8];
                    if (offset_c == OFF_TIMER) timer_nxt_c[8*i +: 8] = data_sram_wdata[8*i +: 8];
                    if ((offset_c == OFF_LED) && (i < 2)) led_nxt_c[8*i +: 8] = data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // RAM contents survive reset; writes are blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (resetn && wr_c && !is_mmio_c) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (data_sram_wen[i]) mem[ram_idx_c][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_q  <= 32'h0;
            led_q    <= 16'h0;
            num_q    <= 32'h0;
            timer_q  <= 32'h0;
            switch_q <= 8'h0;
        end else begin
            if (data_sram_en) rdata_q <= read_c;
            led_q    <= led_nxt_c;
            num_q    <= num_nxt_c;
            timer_q  <= timer_nxt_c;
            switch_q <= switch_in;
        end
    end

    assign data_sram_rdata = rdata_q;
    assign led_out         = led_q;
    assign num_out         = num_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomised self-checking bench for data_sram_responder against a transaction-level model
// (associative-array RAM, plain variables for the MMIO registers).
module tb_data_sram_responder;

    localparam int unsigned RAM_AW = 12;
    localparam int unsigned DEPTH  = 1 << RAM_AW;

    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  sw;
    logic [15:0] led;
    logic [31:0] num;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [31:0] m_mem [int unsigned];
    logic [15:0] m_led;
    logic [31:0] m_num;
    logic [31:0] m_timer;
    logic [7:0]  m_sw;
    logic [31:0] m_rdata;
    logic        m_known;

    data_sram_responder #(.RAM_AW(RAM_AW)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .switch_in       (sw),
        .led_out         (led),
        .num_out         (num)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] lanes);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (lanes[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // One clock: drive at negedge, advance model at posedge, return 1 time unit later.
    task automatic step(input logic rst_v, input logic en_v, input logic [3:0] wen_v,
                        input logic [31:0] a, input logic [31:0] d, input logic [7:0] sw_v);
        logic        mmio;
        int unsigned idx;
        logic [31:0] tnext;
        @(negedge clk);
        resetn = rst_v; en = en_v; wen = wen_v; addr = a; wdata = d; sw = sw_v;
        @(posedge clk);
        mmio = (a[31:16] == 16'hBFAF);
        idx  = (a >> 2) % DEPTH;
        if (!rst_v) begin
            m_led = 0; m_num = 0; m_timer = 0; m_sw = 0; m_rdata = 0; m_known = 1'b1;
        end else begin
            if (en_v) begin
                if (mmio) begin
                    m_known = 1'b1;
                    case (a[15:0])
                        16'hF000: m_rdata = {16'h0, m_led};
                        16'hF010: m_rdata = m_num;
                        16'hF020: m_rdata = {24'h0, m_sw};
                        16'hE000: m_rdata = m_timer;
                        default:  m_rdata = 32'h0;
                    endcase
                end else begin
                    m_known = m_mem.exists(idx);
                    m_rdata = m_known ? m_mem[idx] : 32'h0;
                end
            end
            tnext = m_timer + 32'd1;
            if (en_v && wen_v != 4'b0) begin
                if (!mmio) begin
                    m_mem[idx] = merge(m_mem.exists(idx) ? m_mem[idx] : 32'h0, d, wen_v);
                    if (wen_v != 4'hF && !m_mem.exists(idx)) m_mem.delete(idx);
                end else begin
                    case (a[15:0])
                        16'hF000: m_led = 16'(merge({16'h0, m_led}, d, {2'b00, wen_v[1:0]}));
                        16'hF010: m_num = merge(m_num, d, wen_v);
                        16'hE000: tnext = merge(tnext, d, wen_v);
                        default: ;
                    endcase
                end
            end
            m_timer = tnext;
            m_sw    = sw_v;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 8'h00);
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 8'h00);
        n_checks++;
        if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want %h", rdata, 32'h0); end
        n_checks++;
        if (led !== 16'h0) begin n_fail++; $display("FAIL reset_led got %h want %h", led, 16'h0); end
        n_checks++;
        if (num !== 32'h0) begin n_fail++; $display("FAIL reset_num got %h want %h", num, 32'h0); end
    endtask

    task automatic test_ram_basic();
        step(1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 8'h00);
        step(1'b1, 1'b1, 4'h0, 32'h0000_0010, 32'h0, 8'h00);
        n_checks++;
        if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_basic got %h want %h", rdata, 32'hDEAD_BEEF); end
        // aliased address one RAM span above maps to the same word
        step(1'b1, 1'b1, 4'h0, 32'h0000_0010 + DEPTH * 4, 32'h0, 8'h00);
        n_checks++;
        if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_alias got %h want %h", rdata, 32'hDEAD_BEEF); end
    endtask

    task automatic test_byte_lanes();
        step(1'b1, 1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 8'h00);
        step(1'b1, 1'b1, 4'b0101, 32'h0000_0020, 32'hAABB_CCDD, 8'h00);
        step(1'b1, 1'b1, 4'h0, 32'h0000_0020, 32'h0, 8'h00);
        n_checks++;
        if (rdata !== 32'h11BB_33DD) begin n_fail++; $display("FAIL byte_lanes got %h want %h", rdata, 32'h11BB_33DD); end
    endtask

    task automatic test_read_first();
        step(1'b1, 1'b1, 4'hF, 32'h0000_0030, 32'h0, 8'h00);
        step(1'b1, 1'b1, 4'hF, 32'h0000_0030, 32'h5, 8'h00);
        n_checks++;
        if (rdata !== 32'h0) begin n_fail++; $display("FAIL read_first_old got %h want %h", rdata, 32'h0); end
        step(1'b1, 1'b1, 4'h0, 32'h0000_0030, 32'h0, 8'h00);
        n_checks++;
        if (rdata !== 32'h5) begin n_fail++; $display("FAIL read_first_new got %h want %h", rdata, 32'h5); end
    endtask

    task automatic test_timer();
        logic [31:0] want [3];
        want[0] = 32'hFFFF_FFFE; want[1] = 32'hFFFF_FFFF; want[2] = 32'h0;
        step(1'b1, 1'b1, 4'hF, 32'hBFAF_E000, 32'hFFFF_FFFE, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 4'h0, 32'hBFAF_E000, 32'h0, 8'h00);
            n_checks++;
            if (rdata !== want[i]) begin n_fail++; $display("FAIL timer_wrap%0d got %h want %h", i, rdata, want[i]); end
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0, 32'hBFAF_E000, 32'h0, 8'h00);
        n_checks++;
        if (rdata !== 32'h0) begin n_fail++; $display("FAIL timer_hold got %h want %h", rdata, 32'h0); end
        // partial-lane write: lane 3 forced, other lanes keep counting
        step(1'b1, 1'b1, 4'b1000, 32'hBFAF_E000, 32'h7700_0000, 8'h00);
        step(1'b1, 1'b1, 4'h0, 32'hBFAF_E000, 32'h0, 8'h00);
        n_checks++;
        if (rdata !== m_rdata) begin n_fail++; $display("FAIL timer_lane got %h want %h", rdata, m_rdata); end
    endtask

    task automatic test_mmio();
        step(1'b1, 1'b1, 4'hF, 32'hBFAF_F000, 32'h0001_ABCD, 8'h00);
        n_checks++;
        if (led !== 16'hABCD) begin n_fail++; $display("FAIL led_out got %h want %h", led, 16'hABCD); end
        step(1'b1, 1'b1, 4'h0, 32'hBFAF_F000, 32'h0, 8'h5A);
        n_checks++;
        if (rdata !== 32'h0000_ABCD) begin n_fail++; $display("FAIL led_read got %h want %h", rdata, 32'h0000_ABCD); end
        step(1'b1, 1'b1, 4'hF, 32'hBFAF_F020, 32'hFFFF_FFFF, 8'h5A);
        n_checks++;
        if (rdata !== 32'h0000_005A) begin n_fail++; $display("FAIL switch_read got %h want %h", rdata, 32'h5A); end
        step(1'b1, 1'b1, 4'hF, 32'hBFAF_F030, 32'h1234_5678, 8'h00);
        step(1'b1, 1'b1, 4'h0, 32'hBFAF_F030, 32'h0, 8'h00);
        n_checks++;
        if (rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped got %h want %h", rdata, 32'h0); end
        step(1'b1, 1'b1, 4'hF, 32'hBFAF_F010, 32'hCAFE_F00D, 8'h00);
        n_checks++;
        if (num !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL num_out got %h want %h", num, 32'hCAFE_F00D); end
    endtask

    task automatic test_random();
        logic [31:0] amap [8];
        amap[0] = 32'hBFAF_F000; amap[1] = 32'hBFAF_F010; amap[2] = 32'hBFAF_F020;
        amap[3] = 32'hBFAF_E000; amap[4] = 32'hBFAF_F004; amap[5] = 32'h0000_0100;
        amap[6] = 32'h0000_4100; amap[7] = 32'h1234_0100;
        for (int w = 0; w < 16; w++)
            step(1'b1, 1'b1, 4'hF, 32'h100 + 32'(w * 4), $urandom, 8'($urandom));
        for (int c = 0; c < 300; c++) begin
            logic [31:0] a;
            a = amap[$urandom_range(0, 7)];
            if (a[31:16] != 16'hBFAF) a = a + 32'($urandom_range(0, 15) * 4);
            step(1'b1, 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)) & {4{1'($urandom_range(0, 1))}},
                 a, $urandom, 8'($urandom));
            if (m_known) begin
                n_checks++;
                if (rdata !== m_rdata) begin n_fail++; $display("FAIL rand_rdata c%0d got %h want %h", c, rdata, m_rdata); end
            end
            n_checks++;
            if (led !== m_led || num !== m_num) begin
                n_fail++; $display("FAIL rand_regs c%0d got %h/%h want %h/%h", c, led, num, m_led, m_num);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 4'hF, 32'h0000_0040, 32'h1234_5678, 8'h00);
        step(1'b1, 1'b1, 4'h0, 32'h0000_0040, 32'h0, 8'h00);
        step(1'b0, 1'b1, 4'hF, 32'h0000_0040, 32'hFFFF_FFFF, 8'h00);
        step(1'b0, 1'b1, 4'hF, 32'hBFAF_F000, 32'hFFFF_FFFF, 8'h00);
        n_checks++;
        if (led !== 16'h0) begin n_fail++; $display("FAIL midreset_led got %h want %h", led, 16'h0); end
        n_checks++;
        if (rdata !== 32'h0) begin n_fail++; $display("FAIL midreset_rdata got %h want %h", rdata, 32'h0); end
        step(1'b1, 1'b1, 4'h0, 32'h0000_0040, 32'h0, 8'h00);
        n_checks++;
        if (rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL midreset_ram got %h want %h", rdata, 32'h1234_5678); end
    endtask

    initial begin
        resetn = 1'b0; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0; sw = 8'h0;
        m_led = 0; m_num = 0; m_timer = 0; m_sw = 0; m_rdata = 0; m_known = 1'b1;
        test_reset();
        test_ram_basic();
        test_byte_lanes();
        test_read_first();
        test_timer();
        test_mmio();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
